// File: rtl/johnson_counter_4.sv
// -----------------------------------------------------------------------------
// johnson_counter_4
//   Free-running twisted-ring (Johnson) counter. With WIDTH=4 it steps through
//   an 8-state cycle in which exactly one output bit changes per clock, making
//   it a glitch-free phase/sequence generator. Any state outside the Johnson
//   ring is steered back to all-zeros on the next edge (when SELF_CORRECT=1),
//   so the counter cannot lock up in a parasitic cycle.
//
// Parameters
//   WIDTH         counter width (>= 2); cycle length is 2*WIDTH
//   SELF_CORRECT  1: illegal state -> all-zeros on next edge; 0: plain shift
//
// Ports
//   clk  in   1      rising-edge clock
//   rst  in   1      asynchronous, active-low reset (q forced to 0 while low)
//   q    out  WIDTH  counter state, driven directly from flops
// -----------------------------------------------------------------------------
module johnson_counter_4 #(
    parameter int unsigned WIDTH        = 4,
    parameter bit          SELF_CORRECT = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] q_d;

    // A legal Johnson state (0..01..1 or 1..10..0) has at most one boundary
    // between adjacent bits. Mark each boundary, then require that at most
    // one mark is set (clearing the lowest set bit leaves nothing).
    function automatic logic is_legal(input logic [WIDTH-1:0] v);
        logic [WIDTH-2:0] edges;
        edges = v[WIDTH-2:0] ^ v[WIDTH-1:1];
        return (edges & (edges - 1'b1)) == '0;
    endfunction

    always_comb begin
        q_d = {q_q[WIDTH-2:0], ~q_q[WIDTH-1]};
        if (SELF_CORRECT && !is_legal(q_q)) begin
            q_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: tb/tb_johnson_counter_4.sv
// -----------------------------------------------------------------------------
// tb_johnson_counter_4
//   Directed bench for johnson_counter_4 (WIDTH=4, SELF_CORRECT=1): reset
//   behaviour, two full loops of the sequence, wrap-around, single-bit change
//   per step, mid-run reset and recovery from illegal states.
// -----------------------------------------------------------------------------
module tb_johnson_counter_4;

    logic       clk;
    logic       rst;
    logic [3:0] q;

    int n_assert = 0;
    int n_fail   = 0;

    johnson_counter_4 #(
        .WIDTH        (4),
        .SELF_CORRECT (1'b1)
    ) dut (
        .clk (clk),
        .rst (rst),
        .q   (q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected state after edge k (k counted from 1) following reset release.
    logic [3:0] seq [0:7];

    task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and sample 1 time unit later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [3:0] prev;

        seq[0] = 4'b0001; seq[1] = 4'b0011; seq[2] = 4'b0111; seq[3] = 4'b1111;
        seq[4] = 4'b1110; seq[5] = 4'b1100; seq[6] = 4'b1000; seq[7] = 4'b0000;

        // Reset held across two edges
        rst = 1'b1;
        #1;
        rst = 1'b0;
        #1;
        check("reset_async", q, 4'b0000);
        tick();
        check("reset_edge1", q, 4'b0000);
        tick();
        check("reset_edge2", q, 4'b0000);

        // Release alone does not change q
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("release_no_change", q, 4'b0000);
        tick();
        check("release_first_edge", q, 4'b0001);

        // Reset asserted between edges takes effect immediately
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("reset_between_edges", q, 4'b0000);
        @(negedge clk);
        rst = 1'b1;
        #1;

        // Two full loops, with single-bit change on every step
        prev = q;
        for (int k = 0; k < 16; k++) begin
            tick();
            check($sformatf("seq_%0d", k + 1), q, seq[k % 8]);
            check($sformatf("onehot_%0d", k + 1), 4'($countones(q ^ prev)), 4'd1);
            prev = q;
        end

        // Wrap: walk to 1000, then 0000, then 0001
        for (int k = 0; k < 7; k++) tick();
        check("wrap_at_1000", q, 4'b1000);
        tick();
        check("wrap_to_0000", q, 4'b0000);
        tick();
        check("wrap_to_0001", q, 4'b0001);

        // Mid-run reset at 1110
        for (int k = 0; k < 4; k++) tick();
        check("midrun_at_1110", q, 4'b1110);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("midrun_reset", q, 4'b0000);
        @(negedge clk);
        rst = 1'b1;
        tick();
        check("midrun_recover", q, 4'b0001);

        // Self-correction from 0101
        @(negedge clk);
        force dut.q_q = 4'b0101;
        #1;
        release dut.q_q;
        #1;
        check("forced_0101", q, 4'b0101);
        tick();
        check("selfcorr_0101", q, 4'b0000);
        for (int k = 0; k < 4; k++) tick();
        check("selfcorr_resume_1111", q, 4'b1111);

        // Self-correction from 1011
        @(negedge clk);
        force dut.q_q = 4'b1011;
        #1;
        release dut.q_q;
        #1;
        tick();
        check("selfcorr_1011", q, 4'b0000);
        tick();
        check("selfcorr_1011_next", q, 4'b0001);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
